// File: rtl/rot_amt_finder.sv
// Rotation-amount finder: searches for the smallest k such that rotating a
// (left or right) by k yields y, testing one candidate per clock.
module rot_amt_finder #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  y,
  input  logic          lr,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] amt
);

  localparam int unsigned DW = 2 * W;
  localparam logic [AW-1:0] K_LAST = AW'(W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_reg, a_nxt;
  logic [W-1:0]  y_reg, y_nxt;
  logic          lr_reg, lr_nxt;
  logic [AW-1:0] k, k_nxt;
  logic [AW-1:0] amt_nxt;
  logic          found_nxt;

  logic [DW-1:0] dbl_c;
  logic [W-1:0]  rot_c;
  logic          match_c;

  // Rotate the captured word by candidate k through a doubled copy; compare with target.
  always_comb begin
    dbl_c   = {a_reg, a_reg};
    rot_c   = lr_reg ? W'(dbl_c >> k) : W'((dbl_c << k) >> W);
    match_c = (rot_c == y_reg);
  end

  // Next-state and next-register values for the search sequencer.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    y_nxt     = y_reg;
    lr_nxt    = lr_reg;
    k_nxt     = k;
    amt_nxt   = amt;
    found_nxt = found;
    case (state)
      IDLE: begin
        if (start) begin
          a_nxt     = a;
          y_nxt     = y;
          lr_nxt    = lr;
          k_nxt     = '0;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (match_c) begin
          amt_nxt   = k;
          found_nxt = 1'b1;
          state_nxt = DONE;
        end else if (k == K_LAST) begin
          amt_nxt   = '0;
          found_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          k_nxt = k + AW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, captured operands, candidate counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      y_reg  <= '0;
      lr_reg <= 1'b0;
      k      <= '0;
      amt    <= '0;
      found  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      y_reg  <= y_nxt;
      lr_reg <= lr_nxt;
      k      <= k_nxt;
      amt    <= amt_nxt;
      found  <= found_nxt;
      busy   <= (state_nxt == SEARCH);
      done   <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_rot_amt_finder.sv
// Directed self-checking bench for rot_amt_finder (W = 8).
module tb_rot_amt_finder;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  y;
  logic          lr;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] amt;

  int n_vec = 0;
  int n_err = 0;

  rot_amt_finder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .y     (y),
    .lr    (lr),
    .busy  (busy),
    .done  (done),
    .found (found),
    .amt   (amt)
  );

  always #5 clk = ~clk;

  // Present a one-cycle start; returns just after the accepting edge (edge 0).
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] yv, input logic lv);
    @(negedge clk);
    a = av; y = yv; lr = lv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count busy cycles until done (bounded), capturing the result seen with done.
  task automatic observe(output int bc, output bit got, output logic f, output logic [AW-1:0] am);
    bc = 0; got = 1'b0; f = 1'b0; am = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; f = found; am = amt;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'hA5; y = 8'h5A; lr = 1'b1;
    #2;
    n_vec++;
    if ({busy, done, found, amt} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b amt=%0d, want all 0", busy, done, found, amt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Table of matching cases: direction, identity, extreme amounts.
  task automatic test_match();
    logic [W-1:0] ta [6] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h01, 8'h01};
    logic [W-1:0] ty [6] = '{8'hD2, 8'hB4, 8'h96, 8'h96, 8'h80, 8'h80};
    logic         tl [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int           te [6] = '{3, 3, 0, 0, 1, 7};
    int bc; bit got; logic f; logic [AW-1:0] am;
    for (int i = 0; i < 6; i++) begin
      launch(ta[i], ty[i], tl[i]);
      observe(bc, got, f, am);
      n_vec++;
      if (!got || bc != te[i] + 1) begin
        n_err++;
        $display("FAIL match_latency[%0d]: got done=%b busy_cycles=%0d, want done=1 busy_cycles=%0d", i, got, bc, te[i] + 1);
      end
      n_vec++;
      if (f !== 1'b1 || am !== AW'(te[i])) begin
        n_err++;
        $display("FAIL match_result[%0d]: got found=%b amt=%0d, want found=1 amt=%0d", i, f, am, te[i]);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse[%0d]: got done=%b busy=%b after DONE, want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_no_match();
    logic [W-1:0] ty [2] = '{8'h00, 8'h97};
    int bc; bit got; logic f; logic [AW-1:0] am;
    for (int i = 0; i < 2; i++) begin
      launch(8'h96, ty[i], 1'b1);
      observe(bc, got, f, am);
      n_vec++;
      if (!got || bc != W) begin
        n_err++;
        $display("FAIL nomatch_latency[%0d]: got done=%b busy_cycles=%0d, want done=1 busy_cycles=%0d", i, got, bc, W);
      end
      n_vec++;
      if (f !== 1'b0 || am !== '0) begin
        n_err++;
        $display("FAIL nomatch_result[%0d]: got found=%b amt=%0d, want found=0 amt=0", i, f, am);
      end
    end
  endtask

  // Periodic patterns must report the smallest amount.
  task automatic test_smallest();
    logic [W-1:0] ta [4] = '{8'h55, 8'h55, 8'hFF, 8'h11};
    logic [W-1:0] ty [4] = '{8'hAA, 8'hAA, 8'hFF, 8'h22};
    logic         tl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int           te [4] = '{1, 1, 0, 1};
    int bc; bit got; logic f; logic [AW-1:0] am;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], ty[i], tl[i]);
      observe(bc, got, f, am);
      n_vec++;
      if (!got || f !== 1'b1 || am !== AW'(te[i]) || bc != te[i] + 1) begin
        n_err++;
        $display("FAIL smallest[%0d]: got done=%b found=%b amt=%0d busy=%0d, want 1 1 %0d %0d", i, got, f, am, bc, te[i], te[i] + 1);
      end
    end
  endtask

  // Result stays stable after DONE while idle inputs wander.
  task automatic test_hold();
    int bc; bit got; logic f; logic [AW-1:0] am;
    launch(8'h96, 8'hD2, 1'b1);
    observe(bc, got, f, am);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = a + 8'd17; y = ~y; lr = ~lr;
    end
    n_vec++;
    if (found !== 1'b1 || amt !== 3'd3 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL hold: got found=%b amt=%0d busy=%b done=%b, want 1 3 0 0", found, amt, busy, done);
    end
  endtask

  // Start held high, inputs toggled mid-search; next acceptance in the IDLE cycle after DONE.
  task automatic test_back_to_back();
    int bc; bit got; logic f; logic [AW-1:0] am;
    @(negedge clk);
    a = 8'h96; y = 8'hD2; lr = 1'b1; start = 1'b1;
    @(posedge clk);
    bc = 0; got = 1'b0; f = 1'b0; am = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; f = found; am = amt;
        a = 8'h55; y = 8'hAA; lr = 1'b1;
        break;
      end
      if (busy) bc++;
      a = ~a; y = y + 8'd1; lr = ~lr;
    end
    n_vec++;
    if (!got || bc != 4 || f !== 1'b1 || am !== 3'd3) begin
      n_err++;
      $display("FAIL held_start: got done=%b busy=%0d found=%b amt=%0d, want 1 4 1 3", got, bc, f, am);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL no_queue: got busy=%b done=%b in cycle after DONE, want 0 0", busy, done);
    end
    @(posedge clk);
    #1 start = 1'b0;
    observe(bc, got, f, am);
    n_vec++;
    if (!got || bc != 2 || f !== 1'b1 || am !== 3'd1) begin
      n_err++;
      $display("FAIL back_to_back: got done=%b busy=%0d found=%b amt=%0d, want 1 2 1 1", got, bc, f, am);
    end
  endtask

  // Asynchronous reset mid-search aborts cleanly; a fresh search then works.
  task automatic test_reset_mid();
    int bc; bit got; logic f; logic [AW-1:0] am;
    bit saw;
    launch(8'h96, 8'hD2, 1'b1);
    observe(bc, got, f, am);
    launch(8'h96, 8'h00, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, found, amt} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b found=%b amt=%0d, want all 0", busy, done, found, amt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    n_vec++;
    if (saw) begin
      n_err++;
      $display("FAIL reset_abort: got busy/done activity after release, want none");
    end
    launch(8'h55, 8'hAA, 1'b1);
    observe(bc, got, f, am);
    n_vec++;
    if (!got || bc != 2 || f !== 1'b1 || am !== 3'd1) begin
      n_err++;
      $display("FAIL after_reset: got done=%b busy=%0d found=%b amt=%0d, want 1 2 1 1", got, bc, f, am);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_no_match();
    test_smallest();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
